countdown_timer: RTL and testbench

- Game-round countdown timer. Produces the 8-bit seconds value (0..99) that the board's 2-digit seven-segment display driver consumes on its num input.
- Counts down once per TICK_DIV clock cycles, with start, pause/resume and load controls from debounced one-pulse button logic.
- Signals round expiry to the game FSM.

---
 rtl/countdown_timer.sv | 94 +++++++++
 tb/tb_countdown_timer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: game-round seconds countdown (0..99) with start/pause/load control
// and a one-cycle expiry pulse when counting reaches zero.
module countdown_timer #(
    parameter int TICK_DIV = 100_000_000,
    parameter int INIT_SEC = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] num,
    output logic       running,
    output logic       expired,
    output logic       done
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    state_t        r_state;
    logic [PW-1:0] r_pre;
    logic [7:0]    r_num;
    logic          r_running;
    logic          r_expired;
    logic          r_done;
    logic [7:0]    w_sat;
    logic          w_tick;
    assign w_sat  = (load_val > 8'd99) ? 8'd99 : load_val;
    assign w_tick = r_pre == PRE_MAX;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pre     <= '0;
            r_num     <= 8'(INIT_SEC);
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_num <= w_sat;
                    end else if (start && r_num != 8'd0) begin
                        r_state   <= RUN;
                        r_pre     <= '0;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
                    // pause outranks a tick landing in the same cycle
                    if (pause) begin
                        r_state   <= PAUSE;
                        r_running <= 1'b0;
                    end else if (w_tick) begin
                        r_pre <= '0;
                        r_num <= r_num - 8'd1;
                        if (r_num == 8'd1) begin
                            r_state   <= DONE;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                            r_expired <= 1'b1;
                        end
                    end else begin
                        r_pre <= r_pre + 1'b1;
                    end
                end
                PAUSE: begin
                    if (load) begin
                        r_num   <= w_sat;
                        r_pre   <= '0;
                        r_state <= IDLE;
                    end else if (start) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                DONE: begin
                    if (load) begin
                        r_num   <= w_sat;
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign num     = r_num;
    assign running = r_running;
    assign expired = r_expired;
    assign done    = r_done;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed checks of countdown_timer with TICK_DIV=4, INIT_SEC=60.
module tb_countdown_timer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic [7:0] num;
    logic       running;
    logic       expired;
    logic       done;
    int         n_checks = 0;
    int         n_fail = 0;

    countdown_timer #(.TICK_DIV(4), .INIT_SEC(60)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .load(load),
        .load_val(load_val), .num(num), .running(running), .expired(expired), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic s, input logic p, input logic l, input logic [7:0] v);
        start = s; pause = p; load = l; load_val = v;
        @(negedge clk);
        start = 1'b0; pause = 1'b0; load = 1'b0;
    endtask

    initial begin
        wait_n(2);
        chk("rst_num", num, 60);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_expired", expired, 0);
        rst = 1'b0;
        wait_n(20);
        chk("idle_hold_num", num, 60);
        chk("idle_running", running, 0);
        // basic count: decrements land 4 edges after start is sampled
        pulse(1, 0, 0, 0);
        chk("start_running", running, 1);
        wait_n(3);
        chk("pre_first_dec", num, 60);
        wait_n(1);
        chk("dec_59", num, 59);
        chk("run_running", running, 1);
        wait_n(4);
        chk("dec_58", num, 58);
        wait_n(4);
        chk("dec_57", num, 57);
        // pause with prescaler at 2, resume, decrement 2 cycles later
        wait_n(2);
        pulse(0, 1, 0, 0);
        chk("pause_running", running, 0);
        chk("pause_num", num, 57);
        wait_n(20);
        chk("pause_frozen", num, 57);
        pulse(1, 0, 0, 0);
        chk("resume_running", running, 1);
        wait_n(1);
        chk("resume_plus1", num, 57);
        wait_n(1);
        chk("resume_dec_56", num, 56);
        // pause and start together in RUN: pause wins
        pulse(1, 1, 0, 0);
        chk("coinc_running", running, 0);
        chk("coinc_num", num, 56);
        pulse(1, 0, 0, 0);
        chk("resume2_running", running, 1);
        // pause on the tick cycle suppresses the decrement
        wait_n(3);
        pulse(0, 1, 0, 0);
        chk("pause_tick_num", num, 56);
        chk("pause_tick_running", running, 0);
        pulse(1, 0, 0, 0);
        chk("resume3_num", num, 56);
        wait_n(1);
        chk("held_tick_dec_55", num, 55);
        // load during RUN is ignored
        pulse(0, 0, 1, 8'd10);
        chk("run_load_ignored", num, 55);
        chk("run_load_running", running, 1);
        wait_n(70);
        chk("count_38", num, 38);
        wait_n(1);
        chk("count_37", num, 37);
        // mid-run reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_num", num, 60);
        chk("midrst_running", running, 0);
        wait_n(8);
        chk("midrst_idle", num, 60);
        // saturation and boundary loads in IDLE
        pulse(0, 0, 1, 8'd150);
        chk("sat_150", num, 99);
        pulse(0, 0, 1, 8'd100);
        chk("sat_100", num, 99);
        pulse(0, 0, 1, 8'd99);
        chk("load_99", num, 99);
        // expiry from 2
        pulse(0, 0, 1, 8'd2);
        chk("load_2", num, 2);
        pulse(1, 0, 0, 0);
        wait_n(3);
        chk("exp_pre_num", num, 2);
        wait_n(1);
        chk("exp_num1", num, 1);
        chk("exp_no_pulse_yet", expired, 0);
        wait_n(3);
        chk("exp_num1_hold", num, 1);
        wait_n(1);
        chk("exp_num0", num, 0);
        chk("exp_pulse", expired, 1);
        chk("exp_done", done, 1);
        chk("exp_running", running, 0);
        wait_n(1);
        chk("exp_pulse_one_cycle", expired, 0);
        chk("done_level", done, 1);
        pulse(1, 0, 0, 0);
        chk("done_start_running", running, 0);
        wait_n(5);
        chk("done_start_num", num, 0);
        chk("done_start_expired", expired, 0);
        // reload from DONE
        pulse(0, 0, 1, 8'd5);
        chk("reload_num", num, 5);
        chk("reload_done", done, 0);
        chk("reload_running", running, 0);
        // start with num==0 in IDLE does nothing
        pulse(0, 0, 1, 8'd0);
        pulse(1, 0, 0, 0);
        chk("zero_start_running", running, 0);
        wait_n(5);
        chk("zero_start_num", num, 0);
        chk("zero_start_expired", expired, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
